// File: rtl/adc_disp_pkg.sv
// Shared constants, FSM state type and BCD helper for the ADC display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_disp_pkg;

  localparam int ADC_W   = 12;
  localparam int NDIGITS = 4;
  localparam int BCD_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  // Double-dabble correction: any nibble >= 5 gets +3 so the following
  // left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < NDIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 12-bit binary to 4-digit BCD converter (shift/add-3).
// Latency: start at cycle T -> SHIFT T+1..T+12 -> bcd/done valid at T+13.
// Backpressure: start is only taken in IDLE; caller watches busy.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : load bin and begin a conversion (ignored unless idle)
//   bin        : binary value to convert
//   busy       : conversion in progress (SHIFT or DONE)
//   done       : one-cycle pulse, bcd holds the new result that cycle
//   bcd        : {thousands, hundreds, tens, ones}, held between conversions
module bin2bcd_seq
  import adc_disp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ADC_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_t            state, nxt;
  logic [ADC_W-1:0]       shreg;
  logic [BCD_W-1:0]       scratch;
  logic [3:0]             bitcnt;
  logic [BCD_W+ADC_W-1:0] step;
  logic                   last_shift;

  always_comb begin
    nxt        = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    step       = {add3_nibbles(scratch), shreg} << 1;
    last_shift = (bitcnt == 4'(ADC_W - 1));
    case (state)
      IDLE:    if (start) nxt = SHIFT;
      SHIFT:   if (last_shift) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      bitcnt  <= '0;
      bcd     <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            bitcnt  <= '0;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= step;
          bitcnt           <= bitcnt + 4'd1;
          // The final scratch is written to the output register on the
          // edge entering DONE, so the digits are already visible during
          // the DONE cycle alongside the done pulse.
          if (last_shift) bcd <= step[BCD_W+ADC_W-1 -: BCD_W];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/adc_bcd_converter.sv
// Averages 2^AVG_LOG2 ADC samples and converts the average to 4 BCD digits.
// Latency: 13 cycles from the block-completing acceptance to bcd_valid.
// Backpressure: none upstream; an average arriving while busy is dropped (overrun).
//
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   data, data_valid   : ADC sample and its qualifier (rising edge = one sample)
//   ones..thousands    : BCD digits, held between conversions
//   bcd_valid          : one-cycle pulse when the digits update
//   overrun            : one-cycle pulse when a finished average is dropped
module adc_bcd_converter
  import adc_disp_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] data,
  input  logic             data_valid,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands,
  output logic             bcd_valid,
  output logic             overrun
);

  localparam int SUM_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic             dv_q;
  logic             armed;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] total;
  logic [SUM_W-1:0] avg_full;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             last;
  logic             avg_done;
  logic             start;
  logic             busy;
  logic [ADC_W-1:0] avg;
  logic [BCD_W-1:0] bcd;

  // armed stays low after reset until data_valid has been seen low, so a
  // qualifier held high across reset release is not taken as a new edge.
  assign accept   = data_valid & ~dv_q & armed & ~reset;
  assign last     = (AVG_LOG2 == 0) ? 1'b1 : (count == {CNT_W{1'b1}});
  assign total    = sum + SUM_W'(data);
  assign avg_full = total >> AVG_LOG2;
  assign avg      = avg_full[ADC_W-1:0];
  assign avg_done = accept & last;
  assign start    = avg_done & ~busy;
  assign overrun  = avg_done & busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      dv_q  <= 1'b0;
      armed <= 1'b0;
      sum   <= '0;
      count <= '0;
    end else begin
      dv_q  <= data_valid;
      armed <= armed | ~data_valid;
      if (accept) begin
        if (last) begin
          sum   <= '0;
          count <= '0;
        end else begin
          sum   <= total;
          count <= count + 1'b1;
        end
      end
    end
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (avg),
    .busy  (busy),
    .done  (bcd_valid),
    .bcd   (bcd)
  );

  assign {thousands, hundreds, tens, ones} = bcd;

endmodule
